spi_cmd_sequencer: RTL and testbench

//  Host-side initiator for spi_intf's parallel command port (wr/addr/din in, dout/done/err out).
//  spi_intf restarts a transaction on its own after every done pulse.

---
 rtl/spi_seq_pkg.sv | 24 ++
 rtl/spi_seq_fifo.sv | 51 +++++
 rtl/spi_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI command sequencer.
package spi_seq_pkg;

   typedef enum logic {
      NOP_INFL = 1'b0,
      CMD_INFL = 1'b1
   } seq_state_e;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } cmd_t;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] rdata;
      logic       err;
   } rsp_t;

   localparam logic [7:0] NOP_ADDR_DEF = 8'hFF;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap naturally.
module spi_seq_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_valid,
   output logic                   push_ready,
   input  T                       push_data,
   output logic                   pop_valid,
   input  logic                   pop_ready,
   output T                       pop_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   T             mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign push_ready = (count != (AW+1)'(DEPTH));
   assign pop_valid  = (count != '0);
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop_valid && pop_ready;
   assign pop_data   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Feeds spi_intf one command per transaction (NOP when idle) and returns results through a response FIFO.
// Optional watchdog enabled by defining SPI_SEQ_WDOG_EN.
//
// state    | meaning
// NOP_INFL | controller is running a NOP read (result discarded)
// CMD_INFL | controller is running a real command held in spi_q
module spi_cmd_sequencer
   import spi_seq_pkg::*;
#(
   parameter int         CMD_DEPTH   = 4,
   parameter int         RSP_DEPTH   = 4,
   parameter logic [7:0] NOP_ADDR    = NOP_ADDR_DEF,
   parameter int         WDOG_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_wr,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_wr,
   output logic [7:0] rsp_addr,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       spi_wr,
   output logic [7:0] spi_addr,
   output logic [7:0] spi_din,
   input  logic [7:0] spi_dout,
   input  logic       spi_done,
   input  logic       spi_err,
   output logic       busy,
   output logic       timeout
);

   localparam int CCW = $clog2(CMD_DEPTH) + 1;
   localparam int RCW = $clog2(RSP_DEPTH) + 1;

   seq_state_e     state, state_nxt;
   cmd_t           spi_q, spi_nxt;
   cmd_t           cmd_in, cmd_head;
   rsp_t           rsp_in, rsp_head;
   logic           cmd_head_valid;
   logic           cmd_pop;
   logic           rsp_push;
   logic           rsp_room;
   logic [CCW-1:0] cmd_count;
   logic [RCW-1:0] rsp_count;

   assign cmd_in = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};

   spi_seq_fifo #(.T(cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (cmd_valid),
      .push_ready (cmd_ready),
      .push_data  (cmd_in),
      .pop_valid  (cmd_head_valid),
      .pop_ready  (cmd_pop),
      .pop_data   (cmd_head),
      .count      (cmd_count)
   );

   spi_seq_fifo #(.T(rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (rsp_push),
      .push_ready (rsp_room),
      .push_data  (rsp_in),
      .pop_valid  (rsp_valid),
      .pop_ready  (rsp_ready),
      .pop_data   (rsp_head),
      .count      (rsp_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= NOP_INFL;
         spi_q <= '{wr: 1'b0, addr: NOP_ADDR, data: 8'h00};
      end else begin
         state <= state_nxt;
         spi_q <= spi_nxt;
      end
   end

   // Issue check counts the same-cycle retire but not a same-cycle host pop,
   // so a running controller can never overfill the response FIFO.
   always_comb begin
      state_nxt      = state;
      spi_nxt        = spi_q;
      rsp_push       = 1'b0;
      cmd_pop        = 1'b0;
      rsp_in.wr      = spi_q.wr;
      rsp_in.addr    = spi_q.addr;
      rsp_in.rdata   = spi_q.wr ? 8'h00 : spi_dout;
      rsp_in.err     = spi_err;
      if (spi_done) begin
         rsp_push = (state == CMD_INFL) && rsp_room;
         if (cmd_head_valid &&
             (({1'b0, rsp_count} + (RCW+1)'(state == CMD_INFL)) < (RCW+1)'(RSP_DEPTH))) begin
            cmd_pop   = 1'b1;
            spi_nxt   = cmd_head;
            state_nxt = CMD_INFL;
         end else begin
            spi_nxt   = '{wr: 1'b0, addr: NOP_ADDR, data: 8'h00};
            state_nxt = NOP_INFL;
         end
      end
   end

   assign spi_wr    = spi_q.wr;
   assign spi_addr  = spi_q.addr;
   assign spi_din   = spi_q.data;
   assign rsp_wr    = rsp_head.wr;
   assign rsp_addr  = rsp_head.addr;
   assign rsp_rdata = rsp_head.rdata;
   assign rsp_err   = rsp_head.err;
   assign busy      = (state == CMD_INFL) || (cmd_count != '0);

`ifdef SPI_SEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   logic [WW-1:0] wdog_cnt;
   logic          timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (spi_done) begin
         wdog_cnt <= '0;
      end else if (wdog_cnt != WW'(WDOG_CYCLES)) begin
         wdog_cnt <= wdog_cnt + WW'(1);
         if (wdog_cnt == WW'(WDOG_CYCLES - 1)) timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a behavioural spi_intf/spi_mem stand-in (4-clk transactions).
module tb_spi_cmd_sequencer;
   import spi_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_wr = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic       rsp_wr;
   logic [7:0] rsp_addr;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       spi_wr;
   logic [7:0] spi_addr;
   logic [7:0] spi_din;
   logic [7:0] spi_dout = 8'h00;
   logic       spi_done = 1'b0;
   logic       spi_err = 1'b0;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_cmd_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_wr    (rsp_wr),
      .rsp_addr  (rsp_addr),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .spi_wr    (spi_wr),
      .spi_addr  (spi_addr),
      .spi_din   (spi_din),
      .spi_dout  (spi_dout),
      .spi_done  (spi_done),
      .spi_err   (spi_err),
      .busy      (busy),
      .timeout   (timeout)
   );

   // Controller stand-in: latch command on phase 0, done pulse on phase 3, restart forever.
   logic       model_en = 1'b1;
   int         ph = 0;
   logic       lat_wr;
   logic [7:0] lat_addr;
   logic [7:0] lat_din;
   logic [7:0] mem [32];

   always @(negedge clk) begin
      if (rst || !model_en) begin
         ph       = 0;
         spi_done = 1'b0;
         spi_err  = 1'b0;
      end else begin
         spi_done = 1'b0;
         if (ph == 0) begin
            lat_wr   = spi_wr;
            lat_addr = spi_addr;
            lat_din  = spi_din;
         end
         if (ph == 3) begin
            spi_done = 1'b1;
            if (lat_addr > 8'd31) begin
               spi_err  = 1'b1;
               spi_dout = 8'h00;
            end else begin
               spi_err = 1'b0;
               if (lat_wr) begin
                  mem[lat_addr[4:0]] = lat_din;
                  spi_dout = 8'h00;
               end else begin
                  spi_dout = mem[lat_addr[4:0]];
               end
            end
         end
         ph = (ph == 3) ? 0 : ph + 1;
      end
   end

   logic mon_en = 1'b0;
   logic ready_low_seen = 1'b0;
   always @(negedge clk) if (mon_en && !cmd_ready) ready_low_seen = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
      int w;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      check_eq("push_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_data  = d;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic pop_rsp(input string tag, input logic wr, input logic [7:0] a,
                          input logic [7:0] rd, input logic err, input logic chk_rd);
      int w;
      w = 0;
      @(negedge clk);
      while (!rsp_valid && w < 300) begin
         @(negedge clk);
         w++;
      end
      check_eq({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      check_eq({tag, "_wr"},    {31'd0, rsp_wr},    {31'd0, wr});
      check_eq({tag, "_addr"},  {24'd0, rsp_addr},  {24'd0, a});
      check_eq({tag, "_err"},   {31'd0, rsp_err},   {31'd0, err});
      if (chk_rd) check_eq({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, rd});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      int n_rsp;
      int n_bad;
      int w;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;

      // 1: reset state and idle NOP stream
      do_reset(3);
      #1;
      check_eq("rst_spi_addr", {24'd0, spi_addr}, 32'hFF);
      check_eq("rst_spi_wr",   {31'd0, spi_wr},   32'd0);
      check_eq("rst_spi_din",  {24'd0, spi_din},  32'd0);
      check_eq("rst_rsp_valid",{31'd0, rsp_valid},32'd0);
      check_eq("rst_cmd_ready",{31'd0, cmd_ready},32'd1);
      check_eq("rst_busy",     {31'd0, busy},     32'd0);
      check_eq("rst_timeout",  {31'd0, timeout},  32'd0);
      n_rsp = 0;
      n_bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rsp_valid) n_rsp++;
         if (spi_addr !== 8'hFF || spi_wr !== 1'b0) n_bad++;
      end
      check_eq("idle_rsp_cycles", n_rsp, 0);
      check_eq("idle_non_nop",    n_bad, 0);

      // 2: write then read back
      push_cmd(1'b1, 8'd3, 8'hA5);
      push_cmd(1'b0, 8'd3, 8'h00);
      pop_rsp("wr3", 1'b1, 8'd3, 8'h00, 1'b0, 1'b1);
      pop_rsp("rd3", 1'b0, 8'd3, 8'hA5, 1'b0, 1'b1);

      // 3: out-of-range read errors, following write is clean
      push_cmd(1'b0, 8'd40, 8'h00);
      push_cmd(1'b1, 8'd0, 8'h3C);
      push_cmd(1'b0, 8'd0, 8'h00);
      pop_rsp("rd40", 1'b0, 8'd40, 8'h00, 1'b1, 1'b0);
      pop_rsp("wr0",  1'b1, 8'd0,  8'h00, 1'b0, 1'b1);
      pop_rsp("rd0",  1'b0, 8'd0,  8'h3C, 1'b0, 1'b1);

      // 4: response back-pressure with six queued writes
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) push_cmd(1'b1, 8'(i), 8'(8'h10 + i));
      repeat (60) @(negedge clk);
      mon_en = 1'b0;
      check_eq("bp_ready_low",  {31'd0, ready_low_seen}, 32'd1);
      check_eq("bp_rsp_count",  32'(dut.rsp_count), 32'd4);
      check_eq("bp_cmd_count",  32'(dut.cmd_count), 32'd2);
      check_eq("bp_nop_addr",   {24'd0, spi_addr}, 32'hFF);
      check_eq("bp_nop_wr",     {31'd0, spi_wr},   32'd0);
      check_eq("bp_busy",       {31'd0, busy},     32'd1);
      for (int i = 0; i < 6; i++) pop_rsp("bp", 1'b1, 8'(i), 8'h00, 1'b0, 1'b1);
      push_cmd(1'b0, 8'd5, 8'h00);
      pop_rsp("rd5", 1'b0, 8'd5, 8'h15, 1'b0, 1'b1);

      // 5: reset in the middle of a real write
      push_cmd(1'b1, 8'd7, 8'h11);
      w = 0;
      @(negedge clk);
      while (spi_addr !== 8'd7 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("mid_issued", {24'd0, spi_addr}, 32'd7);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_rst_addr", {24'd0, spi_addr}, 32'hFF);
      check_eq("mid_rst_wr",   {31'd0, spi_wr},   32'd0);
      check_eq("mid_rst_busy", {31'd0, busy},     32'd0);
      @(negedge clk);
      rst = 1'b0;
      n_rsp = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid) n_rsp++;
      end
      check_eq("mid_no_rsp", n_rsp, 0);
      check_eq("end_busy",   {31'd0, busy}, 32'd0);

      // 6: watchdog with the controller stalled
      model_en = 1'b0;
      do_reset(2);
`ifdef SPI_SEQ_WDOG_EN
      w = 0;
      while (w < 200) begin
         @(posedge clk);
         #1;
         w++;
         if (timeout) break;
      end
      check_eq("wdog_cycles", w, 64);
      repeat (20) @(negedge clk);
      check_eq("wdog_sticky", {31'd0, timeout}, 32'd1);
      do_reset(1);
      #1;
      check_eq("wdog_rst_clr", {31'd0, timeout}, 32'd0);
`else
      repeat (100) @(negedge clk);
      check_eq("no_wdog_timeout", {31'd0, timeout}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
